// File: rtl/adc_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_serial_rx_if
// Description : Signal bundle between the dual-channel ADC capture stage and
//               its surroundings: divided serial clock, conversion request,
//               both ADC data lines, chip select and the parallel results.
//               master : system / ADC side (drives sclk_in, start, sdata*)
//               slave  : capture stage (drives cs_n, busy, done, data*, err)
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_serial_rx_if #(
    parameter int DBITS = 12
);
    logic             sclk_in;
    logic             start;
    logic             sdata0;
    logic             sdata1;
    logic             cs_n;
    logic             busy;
    logic             done;
    logic [DBITS-1:0] data0;
    logic [DBITS-1:0] data1;
    logic             err;

    modport master (
        output sclk_in, start, sdata0, sdata1,
        input  cs_n, busy, done, data0, data1, err
    );

    modport slave (
        input  sclk_in, start, sdata0, sdata1,
        output cs_n, busy, done, data0, data1, err
    );
endinterface
`default_nettype wire

// File: rtl/adc_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : adc_serial_rx
// Description : Serial capture stage for a dual-channel 12-bit ADC with two
//               data lines, a shared chip select and NBITS-clock frames.
//               The divided serial clock is sampled in the clk domain and its
//               edges detected; data is shifted in on SCLK rises and the two
//               results are presented with a one-cycle done strobe.
// Ports       : clk, rst (async, active high)
//               bus.sclk_in, bus.start, bus.sdata0, bus.sdata1 (inputs)
//               bus.cs_n, bus.busy, bus.done, bus.data0, bus.data1, bus.err
// Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_rx #(
    parameter int NBITS       = 16,
    parameter int DBITS       = 12,
    parameter int QUIET_EDGES = 1
) (
    input wire             clk,
    input wire             rst,
    adc_serial_rx_if.slave bus
);

    localparam int c_cnt_w = $clog2(NBITS + 1);
    localparam int c_q_w   = (QUIET_EDGES > 1) ? $clog2(QUIET_EDGES) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit   = c_cnt_w'(NBITS - 1);
    localparam logic [c_q_w-1:0]   c_quiet_last = c_q_w'(QUIET_EDGES - 1);

    typedef enum logic [2:0] {
        c_st_idle   = 3'd0,
        c_st_arm    = 3'd1,
        c_st_shift  = 3'd2,
        c_st_finish = 3'd3,
        c_st_quiet  = 3'd4
    } t_state;

    t_state             r_state;
    t_state             w_nxt_state;
    logic               r_sclk_q;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [c_q_w-1:0]   r_quiet_cnt;
    logic [NBITS-1:0]   r_sh0;
    logic [NBITS-1:0]   r_sh1;
    logic [DBITS-1:0]   r_data0;
    logic [DBITS-1:0]   r_data1;
    logic               r_err;
    logic               r_done;
    logic               r_cs_n;
    logic               r_busy;

    logic w_rise;
    logic w_fall;
    logic w_frame_clr;
    logic w_shift;
    logic w_finish;
    logic w_quiet_inc;
    logic w_lead_err;

    // sclk_in comes from the same clk, so one register is enough for a
    // clean single-cycle edge indication.
    assign w_rise = bus.sclk_in & ~r_sclk_q;
    assign w_fall = ~bus.sclk_in & r_sclk_q;

    // Leading bits of the frame must be zero; any 1 flags the result.
    generate
        if (NBITS > DBITS) begin : g_lead
            assign w_lead_err = (|r_sh0[NBITS-1:DBITS]) | (|r_sh1[NBITS-1:DBITS]);
        end else begin : g_no_lead
            assign w_lead_err = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_frame_clr = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        w_quiet_inc = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_nxt_state = c_st_arm;
                end
            end
            c_st_arm: begin
                // Starting on a fall gives the ADC half an SCLK period of
                // setup before the first sampling rise.
                if (w_fall) begin
                    w_frame_clr = 1'b1;
                    w_nxt_state = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_nxt_state = c_st_finish;
                    end
                end
            end
            c_st_finish: begin
                if (w_fall) begin
                    w_finish    = 1'b1;
                    w_nxt_state = c_st_quiet;
                end
            end
            c_st_quiet: begin
                if (w_fall) begin
                    if (r_quiet_cnt == c_quiet_last) begin
                        w_nxt_state = c_st_idle;
                    end else begin
                        w_quiet_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = c_st_idle;
            end
        endcase
    end

    // cs_n and busy are registered from the next state so the ADC pin is
    // glitch free and changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_q    <= 1'b0;
            r_bit_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_sclk_q <= bus.sclk_in;
            r_done   <= w_finish;
            r_cs_n   <= !((w_nxt_state == c_st_shift) || (w_nxt_state == c_st_finish));
            r_busy   <= (w_nxt_state != c_st_idle);
            if (w_frame_clr) begin
                r_bit_cnt <= '0;
                r_sh0     <= '0;
                r_sh1     <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_sh0     <= {r_sh0[NBITS-2:0], bus.sdata0};
                r_sh1     <= {r_sh1[NBITS-2:0], bus.sdata1};
            end
            if (w_finish) begin
                r_data0     <= r_sh0[DBITS-1:0];
                r_data1     <= r_sh1[DBITS-1:0];
                r_err       <= w_lead_err;
                r_quiet_cnt <= '0;
            end else if (w_quiet_inc) begin
                r_quiet_cnt <= r_quiet_cnt + 1'b1;
            end
        end
    end

    assign bus.cs_n  = r_cs_n;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.data0 = r_data0;
    assign bus.data1 = r_data1;
    assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_serial_rx
// Description : Self-checking bench for adc_serial_rx. Generates a divided
//               serial clock (half period 4 clk), models the ADC driving
//               MSB-first frames, and compares every cycle's outputs with a
//               frame-level model of the expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_serial_rx;

    localparam int NBITS       = 16;
    localparam int DBITS       = 12;
    localparam int QUIET_EDGES = 1;
    localparam int HALF        = 4;

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
    } t_frame;

    typedef struct packed {
        logic [11:0] d0;
        logic [11:0] d1;
        logic        e;
    } t_exp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_serial_rx_if #(.DBITS(DBITS)) bus ();

    adc_serial_rx #(
        .NBITS(NBITS),
        .DBITS(DBITS),
        .QUIET_EDGES(QUIET_EDGES)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    t_frame frame_q[$];
    t_exp   exp_q[$];
    int     rise_cnt = 0;
    int     done_cnt = 0;

    // model state
    int          ph = 0;
    int          bit_i = 0;
    int          gap = 1000;
    int          qfalls = 0;
    logic        prev_cs = 1'b1;
    logic        quiet_pending = 1'b0;
    logic [15:0] cw0 = '0;
    logic [15:0] cw1 = '0;
    t_exp        last_exp = '0;
    t_exp        e_tmp = '0;
    t_frame      f_tmp = '0;
    logic        cs_now = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen at %0t", name, $time);
    endtask

    // Serial clock, ADC model and per-cycle output comparison.
    initial begin : p_model
        bus.sclk_in = 1'b0;
        bus.sdata0  = 1'b0;
        bus.sdata1  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_cs_n", bus.cs_n, 1);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_data0", bus.data0, 0);
                check("rst_data1", bus.data1, 0);
                check("rst_err", bus.err, 0);
                last_exp      = '0;
                exp_q.delete();
                prev_cs       = 1'b1;
                quiet_pending = 1'b0;
                rise_cnt      = 0;
                bit_i         = 0;
                gap           = 1000;
            end else begin
                cs_now = bus.cs_n;
                if (!prev_cs && cs_now) begin
                    check("done_at_cs_rise", bus.done, 1);
                end
                if (bus.done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e_tmp = exp_q.pop_front();
                        check("data0", bus.data0, e_tmp.d0);
                        check("data1", bus.data1, e_tmp.d1);
                        check("err", bus.err, e_tmp.e);
                        last_exp = e_tmp;
                    end
                    check("cs_rise_with_done", {prev_cs, cs_now}, 2'b01);
                    check("rises_in_frame", rise_cnt, NBITS);
                    quiet_pending = 1'b1;
                    qfalls        = 0;
                end else begin
                    check("hold_data0", bus.data0, last_exp.d0);
                    check("hold_data1", bus.data1, last_exp.d1);
                    check("hold_err", bus.err, last_exp.e);
                end
                if (quiet_pending && !bus.busy) begin
                    check("quiet_falls", qfalls, QUIET_EDGES);
                    quiet_pending = 1'b0;
                end
                if (!cs_now) begin
                    check("busy_in_frame", bus.busy, 1);
                end
                if (prev_cs && !cs_now) begin
                    check("cs_high_gap_ok", (gap >= 2 * HALF), 1);
                    if (frame_q.size() == 0) begin
                        fail_now("unexpected_frame");
                        cw0 = '0;
                        cw1 = '0;
                    end else begin
                        f_tmp = frame_q.pop_front();
                        cw0   = f_tmp.w0;
                        cw1   = f_tmp.w1;
                        e_tmp.d0 = 12'(cw0 % 16'h1000);
                        e_tmp.d1 = 12'(cw1 % 16'h1000);
                        e_tmp.e  = (cw0 >= 16'h1000) || (cw1 >= 16'h1000);
                        exp_q.push_back(e_tmp);
                    end
                    bit_i      = NBITS - 1;
                    bus.sdata0 = cw0[bit_i];
                    bus.sdata1 = cw1[bit_i];
                    rise_cnt   = 0;
                end
                if (cs_now) begin
                    if (!prev_cs) gap = 0;
                    gap++;
                end
                prev_cs = cs_now;
            end
            ph++;
            if (ph == HALF) begin
                ph = 0;
                bus.sclk_in = ~bus.sclk_in;
                if (bus.sclk_in) begin
                    if (!rst && !bus.cs_n) rise_cnt++;
                end else begin
                    if (quiet_pending) qfalls++;
                    if (!rst && !bus.cs_n) begin
                        if (bit_i > 0) begin
                            bit_i--;
                            bus.sdata0 = cw0[bit_i];
                            bus.sdata1 = cw1[bit_i];
                        end
                    end else begin
                        bus.sdata0 = 1'($urandom_range(0, 1));
                        bus.sdata1 = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1);
        t_frame f;
        f.w0 = w0;
        f.w1 = w1;
        frame_q.push_back(f);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.busy, 0);
    endtask

    task automatic wait_frame_rises(input int k, input string name);
        int n;
        n = 0;
        while (bus.cs_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        while (rise_cnt < k && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, (rise_cnt >= k), 1);
    endtask

    initial begin : p_stim
        logic [15:0] hw0 [3];
        logic [15:0] hw1 [3];
        logic [15:0] r0;
        logic [15:0] r1;
        int          base;

        bus.start = 1'b0;
        rst       = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;

        // Idle after reset, no start.
        repeat (500) @(negedge clk);
        check("idle_cs_n", bus.cs_n, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_data0", bus.data0, 0);
        check("idle_data1", bus.data1, 0);
        check("idle_err", bus.err, 0);
        check("idle_no_done", done_cnt, 0);

        // Single clean frame.
        push_frame(16'h0ABC, 16'h0123);
        pulse_start();
        wait_done("timeout_frame1");
        check("f1_data0", bus.data0, 12'hABC);
        check("f1_data1", bus.data1, 12'h123);
        check("f1_err", bus.err, 0);
        check("f1_busy_after_done", bus.busy, 1);
        wait_idle("f1_idle");

        // Leading one on channel 0, then a clean frame clears err.
        push_frame(16'h8FFF, 16'h0456);
        pulse_start();
        wait_done("timeout_err_frame");
        check("errf_data0", bus.data0, 12'hFFF);
        check("errf_data1", bus.data1, 12'h456);
        check("errf_err", bus.err, 1);
        wait_idle("errf_idle");
        push_frame(16'h0321, 16'h0FED);
        pulse_start();
        wait_done("timeout_clean_frame");
        check("clean_err", bus.err, 0);
        check("clean_data1", bus.data1, 12'hFED);
        wait_idle("clean_idle");

        // start held high: three back-to-back frames.
        hw0[0] = 16'h0111; hw1[0] = 16'h0EEE;
        hw0[1] = 16'h0A5A; hw1[1] = 16'h05A5;
        hw0[2] = 16'h0FFF; hw1[2] = 16'h0000;
        for (int i = 0; i < 3; i++) push_frame(hw0[i], hw1[i]);
        base = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_done("timeout_b2b");
            check("b2b_data0", bus.data0, 32'(hw0[i][11:0]));
            check("b2b_data1", bus.data1, 32'(hw1[i][11:0]));
        end
        bus.start = 1'b0;
        check("b2b_done_count", done_cnt - base, 3);
        wait_idle("b2b_idle");

        // Reset mid-frame after the 7th rise.
        push_frame(16'h0BEE, 16'h0CAF);
        base = done_cnt;
        pulse_start();
        wait_frame_rises(7, "rst_reach_rise7");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", bus.cs_n, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_data0", bus.data0, 0);
        check("midrst_data1", bus.data1, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        check("midrst_data0_kept", bus.data0, 0);
        push_frame(16'h0765, 16'h0432);
        pulse_start();
        wait_done("timeout_after_rst");
        check("after_rst_data0", bus.data0, 12'h765);
        check("after_rst_data1", bus.data1, 12'h432);
        wait_idle("after_rst_idle");

        // start pulses during SHIFT and QUIET are ignored.
        push_frame(16'h0246, 16'h0135);
        base = done_cnt;
        pulse_start();
        wait_frame_rises(5, "ign_reach_rise5");
        pulse_start();
        wait_done("timeout_ignore");
        check("ign_data0", bus.data0, 12'h246);
        check("ign_busy_in_quiet", bus.busy, 1);
        pulse_start();
        repeat (80) @(negedge clk);
        check("ign_one_done", done_cnt - base, 1);
        check("ign_idle", bus.busy, 0);

        // Randomized frames checked against the model.
        for (int i = 0; i < 8; i++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                r0 = r0 % 16'h1000;
                r1 = r1 % 16'h1000;
            end
            push_frame(r0, r1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            pulse_start();
            wait_done("timeout_random");
            wait_idle("random_idle");
        end
        repeat (20) @(negedge clk);
        check("no_pending_expect", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_serial_rx.md
# adc_serial_rx

Serial capture stage for the dual-channel 12-bit ADC (two data lines, shared chip select, 16-clock frames). It sits directly downstream of the clock divider: it takes the divided serial clock as a plain input, samples it in the system clock domain and detects its edges. It drives the ADC chip select and shifts in both data lines. It then presents two parallel 12-bit results with a one-cycle completion strobe.

## Interface
- `NBITS`, default 16: serial clocks per frame.
- `DBITS`, default 12: result width. The first `NBITS-DBITS` bits of each frame are leading zeros.
- `QUIET_EDGES`, default 1: `sclk_in` falling edges during which `cs_n` stays high after a frame, before a new frame may start. Must be ≥1.
- `clk` input, 1 bit: system clock, the same clock that feeds the divider. All state is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `sclk_in` input, 1 bit: divided serial clock, generated from `clk` and therefore synchronous to it. It also drives the ADC SCLK pin directly.
- `start` input, 1 bit: conversion request, sampled every `clk` cycle.
- `sdata0` input, 1 bit: ADC channel 0 serial data.
- `sdata1` input, 1 bit: ADC channel 1 serial data.
- `cs_n` output, 1 bit: ADC chip select, active low.
- `busy` output, 1 bit: high from start acceptance until the quiet time ends.
- `done` output, 1 bit: one-`clk` pulse when `data0`/`data1` update.
- `data0` output, `DBITS` bits: last channel 0 result.
- `data1` output, `DBITS` bits: last channel 1 result.
- `err` output, 1 bit: set with each `done` if any leading bit on either channel was 1. Held until the next `done`.

## Operation
- **Edge detect:**
  - `sclk_q` is `sclk_in` registered once.
  - Rise = `sclk_in & ~sclk_q`.
  - Fall = `~sclk_in & sclk_q`.
  - Each is exactly one `clk` cycle wide.
- **IDLE:**
  - `cs_n`=1, `busy`=0.
  - `start`=1 at a `clk` edge → go to ARM, `busy`=1 from the next cycle.
- **ARM:**
  - Wait for a Fall. On it: `cs_n`←0, bit counter←0, both shift registers←0 → SHIFT.
- **SHIFT:**
  - On each Rise: shift `sdata0`/`sdata1` into the LSB of their `NBITS` shift registers (MSB-first frame), and counter+1.
  - When the counter reaches `NBITS` → FINISH.
- **FINISH:**
  - Wait for a Fall. On it, all in the same edge:
    - `cs_n`←1.
    - `data0`/`data1` ← low `DBITS` bits of the shift registers.
    - `err` ← OR of the upper `NBITS-DBITS` bits of both registers.
    - `done`=1 for that cycle.
  - Quiet counter←0 → QUIET.
- **QUIET:**
  - Count Falls. After `QUIET_EDGES` of them → IDLE, `busy`←0.
- **start handling:**
  - `start` is ignored in every state except IDLE.
  - `start` held high gives back-to-back frames separated by the quiet time.
- **Reset (async, any state, including mid-frame):**
  - State=IDLE, `cs_n`=1, `busy`=0, `done`=0, `err`=0, `data0`=`data1`=0, counters 0, `sclk_q`=0.
  - No partial result is ever presented.
- `data0`/`data1`/`err` change only on `done`.

## Timing
- `cs_n` falls one `clk` after the `clk` edge where `sclk_in` is first seen low, after acceptance. That places the fall about one `clk` after the SCLK falling edge, giving the ADC half an SCLK period of setup before the first rising edge.
- Data is sampled one `clk` after each SCLK rise, i.e. mid-high-phase. Safe for divider ratios ≥ 2 `clk` per half period.
- Frame length: `NBITS` SCLK periods, plus up to one period of ARM alignment.
- `done` and the `cs_n` rise occur in the same cycle, one `clk` after the first SCLK fall following the `NBITS`-th rise.
- Minimum start-to-start spacing with `start` held high: (`NBITS`+`QUIET_EDGES`+1) SCLK periods, plus 1 `clk`.
- With the system divider (`sclk_in` half-period 245 `clk`): a frame takes about 17×490 `clk`.

## Test plan
All cases use a bench-generated `sclk_in` with a half-period of 4 `clk`.
- Reset released, no `start` → `cs_n`=1, `busy`=0, `data0`=`data1`=0, `err`=0, no `done` for 500 cycles.
- One `start` pulse; ADC model drives ch0=0x0ABC and ch1=0x0123 MSB-first on SCLK falls → single `done` pulse, `data0`=0xABC, `data1`=0x123, `err`=0, `cs_n` low for exactly 16 SCLK rises, `busy` drops after 1 quiet fall.
- Ch0 frame 0x8FFF → `data0`=0xFFF, `err`=1. The next clean frame clears `err` to 0.
- `start` held high for 3 frames with varying data → 3 `done` pulses, each with correct data, `cs_n` high ≥1 full SCLK period between frames.
- `rst` asserted after the 7th SCLK rise of a frame → `cs_n`=1 and `busy`=0 asynchronously, `data0`/`data1` remain 0, no `done`. A subsequent `start` completes a correct frame.
- `start` pulses during SHIFT and QUIET → ignored: exactly one `done` per accepted start, and the frame bit count is unaffected.
